// File: rtl/dmem_ws.sv
// dmem_ws: byte-addressed little-endian data memory with a fixed number of
// wait states between request accept and access commit.
// Optional feature: define DMEM_ALIGN_CHK_EN to reject misaligned half/word
// accesses with rsp_err; without it misaligned accesses wrap modulo depth.
module dmem_ws #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int         DEPTH    = 2**ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt;

  // Request fields captured at accept so later input changes are ignored.
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  // Fields of the access being committed: live inputs when committing on the
  // accept edge itself (zero wait states), captured copies otherwise.
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_signed;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  logic                   accept;
  logic                   commit;
  logic                   misaligned;
  logic                   bad;
  logic [3:0][ADDR_W-1:0] ba;
  logic [3:0][7:0]        rb;
  logic [31:0]            load_data;

  logic [7:0] mem [DEPTH];

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid & req_ready;
  assign commit    = ((state == ST_WAIT) && (cnt == 4'd0)) ||
                     (accept && (WAIT_CYCLES == 0));

  assign a_we     = (state == ST_IDLE) ? req_we     : r_we;
  assign a_size   = (state == ST_IDLE) ? req_size   : r_size;
  assign a_signed = (state == ST_IDLE) ? req_signed : r_signed;
  assign a_addr   = (state == ST_IDLE) ? req_addr   : r_addr;
  assign a_wdata  = (state == ST_IDLE) ? req_wdata  : r_wdata;

`ifdef DMEM_ALIGN_CHK_EN
  assign misaligned = ((a_size == 2'b01) && a_addr[0]) ||
                      ((a_size == 2'b11) && (a_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bad = (a_size == 2'b10) || misaligned;

  // Byte addresses addr+k wrap naturally at the top of memory.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ba[k] = a_addr + ADDR_W'(k);
      rb[k] = mem[ba[k]];
    end
  end

  // Load result assembly with sign/zero extension for byte and half.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    load_data = 32'd0;
    case (a_size)
      2'b00:   load_data = {{24{a_signed & rb[0][7]}}, rb[0]};
      2'b01:   load_data = {{16{a_signed & rb[1][7]}}, rb[1], rb[0]};
      2'b11:   load_data = {rb[3], rb[2], rb[1], rb[0]};
      default: load_data = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)       state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        cnt      <= CNT_INIT;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= bad;
        rsp_rdata <= (a_we || bad) ? 32'd0 : load_data;
      end
    end
  end

  // Storage write on the commit edge; a reset during WAIT leaves the FSM in
  // IDLE so the aborted access never commits.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so contents survive rst_n and map to RAM.
    if (commit && a_we && !bad) begin
      mem[ba[0]] <= a_wdata[7:0];
      if (a_size != 2'b00) mem[ba[1]] <= a_wdata[15:8];
      if (a_size == 2'b11) begin
        mem[ba[2]] <= a_wdata[23:16];
        mem[ba[3]] <= a_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: directed bench for dmem_ws with three instances
// (WAIT_CYCLES = 1, 3, 0) sharing one clock.
module tb_dmem_ws;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_n, req_valid, req_ready, req_we, req_signed;
  logic [N-1:0]       rsp_valid, rsp_ready, rsp_err;
  logic [N-1:0][1:0]  req_size;
  logic [N-1:0][7:0]  req_addr;
  logic [N-1:0][31:0] req_wdata, rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int wc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_ws #(
      .ADDR_W     (8),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_size  (req_size[g]),
      .req_signed(req_signed[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, return #1 after the accept edge with the inputs scrambled.
  task automatic issue(input int i, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [7:0] addr, input logic [31:0] wd);
    req_we[i]     = we;
    req_size[i]   = size;
    req_signed[i] = sgn;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    @(posedge clk); #1;
    req_valid[i]  = 1'b0;
    req_we[i]     = ~we;
    req_size[i]   = 2'b11;
    req_signed[i] = ~sgn;
    req_addr[i]   = ~addr;
    req_wdata[i]  = ~wd;
  endtask

  // Wait (bounded) for the response; lat counts the accept cycle as 1.
  task automatic wait_rsp(input int i, output int lat);
    lat = 1;
    while (!rsp_valid[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full access with rsp_ready high: checks latency, data and error flag.
  task automatic xfer(input string tag, input int i, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    issue(i, we, size, sgn, addr, wd);
    wait_rsp(i, lat);
    check({tag, "_lat"}, 32'(lat), 32'(wc(i) + 1));
    check({tag, "_rd"}, rsp_rdata[i], exp_rd);
    check({tag, "_err"}, {31'd0, rsp_err[i]}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n      = '0;
    req_valid  = '0;
    req_we     = '0;
    req_size   = '0;
    req_signed = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = '1;
    @(posedge clk); #1;

    check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);

    // Instance 0, one wait state: loads with every size and extension.
    xfer("st_w",    0, 1'b1, 2'b11, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    xfer("ld_w",    0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    xfer("ld_b_s",  0, 1'b0, 2'b00, 1'b1, 8'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    xfer("ld_b_u",  0, 1'b0, 2'b00, 1'b0, 8'h13, 32'h0,        32'h000000DE, 1'b0);
    xfer("ld_h_s",  0, 1'b0, 2'b01, 1'b1, 8'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    xfer("ld_h_u",  0, 1'b0, 2'b01, 1'b0, 8'h10, 32'h0,        32'h0000BEEF, 1'b0);
    xfer("ld_h12s", 0, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    xfer("ld_b10s", 0, 1'b0, 2'b00, 1'b1, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    xfer("ld_w_s",  0, 1'b0, 2'b11, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0);

    // Back-pressure: response held five cycles with rsp_ready low.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
    wait_rsp(0, lat);
    check("hold_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("hold_ready", {31'd0, req_ready[0]}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("rel_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rel_ready", {31'd0, req_ready[0]}, 32'd1);

    // Byte and half stores into the word at 0x10.
    xfer("st_b",    0, 1'b1, 2'b00, 1'b0, 8'h11, 32'h1234567A, 32'h0,        1'b0);
    xfer("ld_w2",   0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'hDEAD7AEF, 1'b0);
    xfer("st_h",    0, 1'b1, 2'b01, 1'b0, 8'h12, 32'hFFFF8001, 32'h0,        1'b0);
    xfer("ld_w3",   0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'h80017AEF, 1'b0);
    xfer("ld_h12",  0, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0,        32'hFFFF8001, 1'b0);
    xfer("ld_b12u", 0, 1'b0, 2'b00, 1'b0, 8'h12, 32'h0,        32'h00000001, 1'b0);

    // Reserved size: error, zero data, no write.
    xfer("err_ld",  0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h0,        1'b1);
    xfer("err_st",  0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hFFFFFFFF, 32'h0,        1'b1);
    xfer("ld_w4",   0, 1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'h80017AEF, 1'b0);

`ifdef DMEM_ALIGN_CHK_EN
    xfer("al_st0",  0, 1'b1, 2'b11, 1'b0, 8'h00, 32'hAABBCCDD, 32'h0,        1'b0);
    xfer("al_mis",  0, 1'b1, 2'b11, 1'b0, 8'h02, 32'h11223344, 32'h0,        1'b1);
    xfer("al_half", 0, 1'b0, 2'b01, 1'b0, 8'h11, 32'h0,        32'h0,        1'b1);
    xfer("al_ld0",  0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0,        32'hAABBCCDD, 1'b0);
`else
    xfer("wrap_st", 0, 1'b1, 2'b11, 1'b0, 8'hFE, 32'h11223344, 32'h0,        1'b0);
    xfer("wrap_fe", 0, 1'b0, 2'b00, 1'b0, 8'hFE, 32'h0,        32'h00000044, 1'b0);
    xfer("wrap_ff", 0, 1'b0, 2'b00, 1'b0, 8'hFF, 32'h0,        32'h00000033, 1'b0);
    xfer("wrap_00", 0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0,        32'h00000022, 1'b0);
    xfer("wrap_01", 0, 1'b0, 2'b00, 1'b0, 8'h01, 32'h0,        32'h00000011, 1'b0);
    xfer("wrap_lw", 0, 1'b0, 2'b11, 1'b0, 8'hFE, 32'h0,        32'h11223344, 1'b0);
    xfer("mis_h11", 0, 1'b0, 2'b01, 1'b1, 8'h11, 32'h0,        32'h0000017A, 1'b0);
`endif

    // Instance 1, three wait states: reset during WAIT aborts a store.
    xfer("ab_pre",  1, 1'b1, 2'b11, 1'b0, 8'h20, 32'h01020304, 32'h0,        1'b0);
    issue(1, 1'b1, 2'b11, 1'b0, 8'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("ab_rst_valid", {31'd0, rsp_valid[1]}, 32'd0);
    end
    rst_n[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("ab_post_valid", {31'd0, rsp_valid[1]}, 32'd0);
    end
    check("ab_ready", {31'd0, req_ready[1]}, 32'd1);
    xfer("ab_ld",   1, 1'b0, 2'b11, 1'b0, 8'h20, 32'h0,        32'h01020304, 1'b0);

    // Instance 2, zero wait states.
    xfer("z_st",    2, 1'b1, 2'b11, 1'b0, 8'h40, 32'h55667788, 32'h0,        1'b0);
    xfer("z_ld_h",  2, 1'b0, 2'b01, 1'b0, 8'h42, 32'h0,        32'h00005566, 1'b0);
    xfer("z_err",   2, 1'b0, 2'b10, 1'b0, 8'h40, 32'h0,        32'h0,        1'b1);
    xfer("z_err_st",2, 1'b1, 2'b10, 1'b0, 8'h40, 32'hFFFFFFFF, 32'h0,        1'b1);
    xfer("z_ld_w",  2, 1'b0, 2'b11, 1'b0, 8'h40, 32'h0,        32'h55667788, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
